aer_tx_handshake: RTL
=====================

// Module: aer_tx_handshake
// PURPOSE
//   Downstream AER transmitter for the pixel-index encoder. Captures each 10-bit
//   index the encoder presents on AER_IN_ADDR/AER_IN_VALID and drives it off-block
//   over a 4-phase REQ/ACK link to the neuromorphic core.
//   Back-pressures the encoder through AER_IN_BUSY until the handshake completes.
//   Also reports a saturating event counter and sticky timeout/overrun flags.
// PARAMETERS
//   ADDR_BITS     10     AER address width
//   ACK_TIMEOUT   1023   cycles allowed per ACK phase before abort (>=4)
//   TO_BITS       10     timeout counter width, must hold ACK_TIMEOUT
//   CNT_BITS      16     event counter width
// PORTS
//   CLK          in   1          clock
//   RST          in   1          reset, asynchronous, active-high
//   AER_IN_ADDR  in   ADDR_BITS  index from encoder; held stable after VALID falls
//   AER_IN_VALID in   1          encoder index-valid strobe (1-2 cycle burst)
//   AER_IN_BUSY  out  1          transfer in progress; encoder must wait
//   AER_ADDR     out  ADDR_BITS  address on the AER link
//   AER_REQ      out  1          AER request
//   AER_ACK      in   1          AER acknowledge, asynchronous to CLK
//   ERR_CLR      in   1          clears TIMEOUT_ERR and OVERRUN_ERR
//   EVT_COUNT    out  CNT_BITS   completed handshakes, saturating
//   TIMEOUT_ERR  out  1          sticky: an ACK phase timed out
//   OVERRUN_ERR  out  1          sticky: capture attempted while not IDLE
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; AER_REQ=0, AER_ADDR=0, EVT_COUNT=0, both
//   ERR flags=0, sync flops=0, valid_q=0, timeout counter=0. AER_IN_BUSY=0.
// - AER_ACK passes a 2-flop synchroniser to ack_s; handshake logic uses ack_s only.
// - valid_q registers AER_IN_VALID. capture = valid_q & ~AER_IN_VALID (the falling
//   edge: the index is valid in the last VALID cycle and the cycle after).
// - AER_IN_BUSY = (state != IDLE) | capture. It is combinational, so it is high
//   in the capture cycle itself.
// - FSM (registered):
//   IDLE:    capture -> AER_ADDR <= AER_IN_ADDR, AER_REQ <= 1, to=0, -> REQ.
//   REQ:     ack_s=1 -> AER_REQ <= 0, to=0, -> RELEASE.
//            to==ACK_TIMEOUT -> AER_REQ <= 0, TIMEOUT_ERR <= 1, to=0, -> RELEASE.
//            else to++.
//   RELEASE: ack_s=0 -> IDLE. EVT_COUNT++ (saturates at all-ones) only when
//            the REQ phase ended by ACK, not by timeout.
//            to==ACK_TIMEOUT -> TIMEOUT_ERR <= 1, -> IDLE. else to++.
// - Latency: AER_REQ rises 1 cycle after capture. After AER_ACK falls, AER_IN_BUSY
//   falls 3 cycles later (2 sync + 1 state).
// - AER_ADDR holds its last value in IDLE. AER_REQ is high only in REQ.
// - capture while state != IDLE: ignored (no address update); OVERRUN_ERR <= 1.
// - ERR_CLR clears both flags; a set event in the same cycle wins.
// - ACK already high on entry to REQ: accepted on first ack_s=1 (no edge required).
// - Address 0x1FF (encoder reset marker) is transmitted like any other index.
// TESTING
// 1 Reset mid-REQ: RST pulse while AER_REQ=1 -> REQ=0, BUSY=0, EVT_COUNT=0 in the
//   same cycle; the next capture starts cleanly.
// 2 Normal: VALID high 2 cycles, ADDR=0x02A; ACK responder 3-cycle delay ->
//   AER_ADDR=0x02A, REQ 1 cycle after capture, BUSY falls 3 cycles after ACK falls,
//   EVT_COUNT=1.
// 3 Encoder sequence: 0x1FF, 0x1FF, then indices 5,7,200 -> four-phase ordering
//   respected, EVT_COUNT=5, no ERR flags.
// 4 Timeout: ACK never asserted, ACK_TIMEOUT=8 -> REQ drops after 9 REQ cycles,
//   TIMEOUT_ERR=1, EVT_COUNT unchanged, back in IDLE.
// 5 Overrun: second VALID falling edge during REQ -> OVERRUN_ERR=1, AER_ADDR keeps
//   the first value; ERR_CLR pulse -> both flags 0.
// 6 Saturation: CNT_BITS=4, 17 transfers -> EVT_COUNT=4'hF.

Source files
------------

// File: rtl/aer_tx_handshake.sv
// AER link transmitter: captures encoder indices and drives them out over a 4-phase REQ/ACK
// handshake, with a saturating event counter and sticky timeout/overrun flags.
module aer_tx_handshake #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned ACK_TIMEOUT = 1023,
    parameter int unsigned TO_BITS     = 10,
    parameter int unsigned CNT_BITS    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_BITS-1:0] AER_IN_ADDR,
    input  logic                 AER_IN_VALID,
    output logic                 AER_IN_BUSY,
    output logic [ADDR_BITS-1:0] AER_ADDR,
    output logic                 AER_REQ,
    input  logic                 AER_ACK,
    input  logic                 ERR_CLR,
    output logic [CNT_BITS-1:0]  EVT_COUNT,
    output logic                 TIMEOUT_ERR,
    output logic                 OVERRUN_ERR
);

    typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;

    localparam logic [TO_BITS-1:0] ToMax = TO_BITS'(ACK_TIMEOUT);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 req_q, req_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [TO_BITS-1:0]   to_q, to_d;
    logic                 to_err_q, to_err_d;
    logic                 ov_err_q, ov_err_d;
    logic                 acked_q, acked_d;
    logic                 ack_meta_q, ack_s_q;
    logic                 valid_q;
    logic                 capture;
    logic                 to_hit;

    // Encoder holds the index for one cycle after VALID drops, so capture on the falling edge.
    assign capture = valid_q & ~AER_IN_VALID;
    assign to_hit  = (to_q == ToMax);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        acked_d  = acked_q;
        to_err_d = to_err_q & ~ERR_CLR;
        ov_err_d = ov_err_q & ~ERR_CLR;

        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    addr_d  = AER_IN_ADDR;
                    req_d   = 1'b1;
                    to_d    = '0;
                    acked_d = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (capture) ov_err_d = 1'b1;
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    to_d    = '0;
                    acked_d = 1'b1;
                    state_d = StRelease;
                end else if (to_hit) begin
                    req_d    = 1'b0;
                    to_d     = '0;
                    acked_d  = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = StRelease;
                end else begin
                    to_d = to_q + TO_BITS'(1);
                end
            end
            StRelease: begin
                if (capture) ov_err_d = 1'b1;
                if (!ack_s_q) begin
                    // Aborted (timed-out) requests are not counted as events.
                    if (acked_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_BITS'(1);
                    state_d = StIdle;
                end else if (to_hit) begin
                    to_err_d = 1'b1;
                    state_d  = StIdle;
                end else begin
                    to_d = to_q + TO_BITS'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            to_q       <= '0;
            to_err_q   <= 1'b0;
            ov_err_q   <= 1'b0;
            acked_q    <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            to_err_q   <= to_err_d;
            ov_err_q   <= ov_err_d;
            acked_q    <= acked_d;
            ack_meta_q <= AER_ACK;
            ack_s_q    <= ack_meta_q;
            valid_q    <= AER_IN_VALID;
        end
    end

    assign AER_IN_BUSY = (state_q != StIdle) | capture;
    assign AER_ADDR    = addr_q;
    assign AER_REQ     = req_q;
    assign EVT_COUNT   = cnt_q;
    assign TIMEOUT_ERR = to_err_q;
    assign OVERRUN_ERR = ov_err_q;

endmodule
